trace_capture: RTL and testbench

- Reader/consumer side of the processor commit-trace interface (trace_val/trace_addr/trace_data).
- Captures committed-instruction trace records into a show-ahead FIFO, starting at a programmable trigger PC.
- Drains the records over a valid/ready port to a host/debug shim.
- Sits beside the processor on the FPGA top level as an on-chip replacement for simulation trace checking.

---
 rtl/trace_capture_pkg.sv | 18 +
 rtl/trace_capture_fifo.sv | 70 +++++++
 rtl/trace_capture.sv | 117 +++++++++++
 tb/tb_trace_capture.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/trace_capture_pkg.sv
// Shared types and constants for the trace_capture block.
package trace_capture_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2
    } state_e;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] tstamp;
    } trace_entry_t;

    localparam logic [15:0] OVF_MAX = 16'hFFFF;

endpackage

// File: rtl/trace_capture_fifo.sv
// Show-ahead FIFO of trace records; clear has priority over enq/deq.
module trace_capture_fifo
    import trace_capture_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             enq,
    input  trace_entry_t     enq_entry,
    input  logic             deq,
    output trace_entry_t     head,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);

    trace_entry_t     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (enq) wr_ptr_d = wr_ptr_q + 1'b1;
            if (deq) rd_ptr_d = rd_ptr_q + 1'b1;
            case ({enq, deq})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is deliberately not reset; count gates visibility, so stale contents never leak.
    always_ff @(posedge clk) begin
        if (enq && !clear) mem_q[wr_ptr_q] <= enq_entry;
    end

    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_W'(DEPTH));
    assign count = count_q;
    assign head  = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/trace_capture.sv
// Commit-trace capture: trigger FSM, show-ahead record FIFO, overflow counter.
// Optional per-record cycle timestamp under `define TRACE_CAPTURE_TSTAMP_EN.
module trace_capture
    import trace_capture_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             trace_val,
    input  logic [31:0]      trace_addr,
    input  logic [31:0]      trace_data,
    input  logic             arm,
    input  logic [31:0]      trig_addr,
    input  logic             clear,
    output logic             deq_val,
    input  logic             deq_rdy,
    output logic [31:0]      deq_addr,
    output logic [31:0]      deq_data,
    output logic [31:0]      deq_tstamp,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic [15:0]      overflow_cnt,
    output logic [1:0]       state
);

    state_e       state_q, state_d;
    logic [15:0]  ovf_q, ovf_d;
    logic         trig_hit, cap, deq_fire, enq, drop, empty;
    logic [31:0]  enq_tstamp;
    trace_entry_t enq_entry, head;

    assign trig_hit = trace_val && (trace_addr == trig_addr);

    always_comb begin
        state_d = state_q;
        if (!arm) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    state_d = ARMED;
                ARMED:   if (trig_hit) state_d = CAPTURE;
                CAPTURE: state_d = CAPTURE;
                default: state_d = IDLE;
            endcase
        end
    end

    // The triggering record itself is captured, not just those after it.
    assign cap      = arm && trace_val &&
                      ((state_q == CAPTURE) || (state_q == ARMED && trace_addr == trig_addr));
    assign deq_fire = !empty && deq_rdy;
    assign enq      = cap && (!full || deq_fire);
    assign drop     = cap && full && !deq_fire;

    always_comb begin
        ovf_d = ovf_q;
        if (clear)                       ovf_d = '0;
        else if (drop && ovf_q != OVF_MAX) ovf_d = ovf_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            ovf_q   <= '0;
        end else begin
            state_q <= state_d;
            ovf_q   <= ovf_d;
        end
    end

`ifdef TRACE_CAPTURE_TSTAMP_EN
    logic [31:0] tstamp_q, tstamp_d;

    assign tstamp_d = tstamp_q + 32'd1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) tstamp_q <= '0;
        else      tstamp_q <= tstamp_d;
    end

    assign enq_tstamp = tstamp_q;
    assign deq_tstamp = head.tstamp;
`else
    logic unused_tstamp;

    assign enq_tstamp    = '0;
    assign deq_tstamp    = '0;
    assign unused_tstamp = ^head.tstamp;
`endif

    assign enq_entry = '{addr: trace_addr, data: trace_data, tstamp: enq_tstamp};

    trace_capture_fifo #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .enq       (enq),
        .enq_entry (enq_entry),
        .deq       (deq_fire),
        .head      (head),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    assign deq_val      = !empty;
    assign deq_addr     = head.addr;
    assign deq_data     = head.data;
    assign overflow_cnt = ovf_q;
    assign state        = state_q;

endmodule

// File: tb/tb_trace_capture.sv
// Self-checking bench for trace_capture: directed table, corner sequences, random vs queue model.
module tb_trace_capture;

    localparam int DEPTH = 8;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             clk;
    logic             rst;
    logic             trace_val;
    logic [31:0]      trace_addr;
    logic [31:0]      trace_data;
    logic             arm;
    logic [31:0]      trig_addr;
    logic             clear;
    logic             deq_val;
    logic             deq_rdy;
    logic [31:0]      deq_addr;
    logic [31:0]      deq_data;
    logic [31:0]      deq_tstamp;
    logic [CNT_W-1:0] count;
    logic             full;
    logic [15:0]      overflow_cnt;
    logic [1:0]       state;

    trace_capture #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .trace_val    (trace_val),
        .trace_addr   (trace_addr),
        .trace_data   (trace_data),
        .arm          (arm),
        .trig_addr    (trig_addr),
        .clear        (clear),
        .deq_val      (deq_val),
        .deq_rdy      (deq_rdy),
        .deq_addr     (deq_addr),
        .deq_data     (deq_data),
        .deq_tstamp   (deq_tstamp),
        .count        (count),
        .full         (full),
        .overflow_cnt (overflow_cnt),
        .state        (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    // Behavioural reference: an unbounded queue trimmed to DEPTH, plus a trigger state and cycle count.
    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] ts;
    } rec_t;

    rec_t        mq[$];
    int          m_state;
    int          m_ovf;
    logic [31:0] m_cyc;
    bit          collect;
    logic [31:0] out_q[$];

    task automatic model_reset();
        mq.delete();
        m_state = 0;
        m_ovf   = 0;
        m_cyc   = 0;
    endtask

    task automatic model_compare();
        logic [31:0] e_addr, e_data, e_ts;
        e_addr = 0; e_data = 0; e_ts = 0;
        if (mq.size() > 0) begin
            e_addr = mq[0].addr;
            e_data = mq[0].data;
`ifdef TRACE_CAPTURE_TSTAMP_EN
            e_ts   = mq[0].ts;
`endif
        end
        check("m_count",  32'(count),        32'(mq.size()));
        check("m_full",   32'(full),         32'(mq.size() == DEPTH));
        check("m_val",    32'(deq_val),      32'(mq.size() > 0));
        check("m_addr",   deq_addr,          e_addr);
        check("m_data",   deq_data,          e_data);
        check("m_tstamp", deq_tstamp,        e_ts);
        check("m_ovf",    32'(overflow_cnt), 32'(m_ovf));
        check("m_state",  32'(state),        32'(m_state));
    endtask

    task automatic model_update();
        bit cap, dq, fl;
        cap = trace_val && arm && (m_state == 2 || (m_state == 1 && trace_addr == trig_addr));
        dq  = (mq.size() > 0) && deq_rdy;
        fl  = (mq.size() == DEPTH);
        if (clear) begin
            mq.delete();
            m_ovf = 0;
        end else begin
            if (dq) void'(mq.pop_front());
            if (cap && (!fl || dq)) mq.push_back(rec_t'{trace_addr, trace_data, m_cyc});
            else if (cap && m_ovf < 65535) m_ovf++;
        end
        if (!arm) m_state = 0;
        else if (m_state == 0) m_state = 1;
        else if (m_state == 1 && trace_val && trace_addr == trig_addr) m_state = 2;
        m_cyc++;
    endtask

    // Inputs are set just after a rising edge; outputs are compared mid-cycle.
    task automatic tick();
        @(negedge clk);
        model_compare();
        if (collect && deq_val && deq_rdy) out_q.push_back(deq_addr);
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] d);
        trace_val  = 1'b1;
        trace_addr = a;
        trace_data = d;
        tick();
        trace_val  = 1'b0;
    endtask

    typedef struct {
        logic        arm;
        logic        tv;
        logic [31:0] ta;
        logic [31:0] td;
        logic        rdy;
        logic [1:0]  e_state;
        int          e_count;
        logic        e_val;
        logic [31:0] e_addr;
    } vec_t;

    vec_t vt[7];

    initial begin
        vt[0] = '{1'b1, 1'b0, 32'h000, 32'h00, 1'b0, 2'd1, 0, 1'b0, 32'h000};
        vt[1] = '{1'b1, 1'b1, 32'h1F8, 32'h11, 1'b0, 2'd1, 0, 1'b0, 32'h000};
        vt[2] = '{1'b1, 1'b1, 32'h1FC, 32'h22, 1'b0, 2'd1, 0, 1'b0, 32'h000};
        vt[3] = '{1'b1, 1'b1, 32'h200, 32'h33, 1'b0, 2'd2, 1, 1'b1, 32'h200};
        vt[4] = '{1'b1, 1'b1, 32'h204, 32'h44, 1'b0, 2'd2, 2, 1'b1, 32'h200};
        vt[5] = '{1'b1, 1'b0, 32'h000, 32'h00, 1'b1, 2'd2, 1, 1'b1, 32'h204};
        vt[6] = '{1'b1, 1'b0, 32'h000, 32'h00, 1'b1, 2'd2, 0, 1'b0, 32'h000};

        rst = 1'b0; trace_val = 1'b0; trace_addr = '0; trace_data = '0;
        arm = 1'b0; trig_addr = 32'h200; clear = 1'b0; deq_rdy = 1'b0;
        collect = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;

        check("rst_count", 32'(count), 0);
        check("rst_val",   32'(deq_val), 0);
        check("rst_full",  32'(full), 0);
        check("rst_ovf",   32'(overflow_cnt), 0);
        check("rst_state", 32'(state), 0);
        check("rst_addr",  deq_addr, 0);

        // Trigger and in-order drain.
        for (int i = 0; i < 7; i++) begin
            arm = vt[i].arm; trace_val = vt[i].tv; trace_addr = vt[i].ta;
            trace_data = vt[i].td; deq_rdy = vt[i].rdy;
            tick();
            check($sformatf("vec%0d_state", i), 32'(state),   32'(vt[i].e_state));
            check($sformatf("vec%0d_count", i), 32'(count),   32'(vt[i].e_count));
            check($sformatf("vec%0d_val", i),   32'(deq_val), 32'(vt[i].e_val));
            check($sformatf("vec%0d_addr", i),  deq_addr,     vt[i].e_addr);
        end
        trace_val = 1'b0; deq_rdy = 1'b0;

        // Fill past capacity.
        for (int i = 0; i < 11; i++) begin
            push(32'h1000 + 32'(4 * i), 32'(i));
            if (i == 6) check("full_after_7", 32'(full), 0);
            if (i == 7) check("full_after_8", 32'(full), 1);
        end
        check("ovf_after_11",   32'(overflow_cnt), 3);
        check("count_after_11", 32'(count), 8);
        deq_rdy = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("drain%0d_addr", i), deq_addr, 32'h1000 + 32'(4 * i));
            check($sformatf("drain%0d_data", i), deq_data, 32'(i));
            tick();
        end
        check("drain_count", 32'(count), 0);
        check("drain_val",   32'(deq_val), 0);
        deq_rdy = 1'b0;

        // Full with a simultaneous dequeue accepts the record.
        clear = 1'b1; tick(); clear = 1'b0;
        check("clear_ovf", 32'(overflow_cnt), 0);
        for (int i = 0; i < 8; i++) push(32'h2000 + 32'(4 * i), 32'(i));
        deq_rdy = 1'b1;
        push(32'h2020, 32'h8);
        check("fulldeq_count", 32'(count), 8);
        check("fulldeq_head",  deq_addr, 32'h2004);
        check("fulldeq_ovf",   32'(overflow_cnt), 0);
        repeat (7) tick();
        check("fulldeq_last",  deq_addr, 32'h2020);
        tick();
        check("fulldeq_empty", 32'(count), 0);
        deq_rdy = 1'b0;

        // Clear alongside a capture wins.
        for (int i = 0; i < 10; i++) push(32'h3000 + 32'(4 * i), 32'(i));
        check("pre_clear_ovf", 32'(overflow_cnt), 2);
        clear = 1'b1;
        push(32'h3100, 32'h99);
        clear = 1'b0;
        check("clr_count", 32'(count), 0);
        check("clr_ovf",   32'(overflow_cnt), 0);
        check("clr_val",   32'(deq_val), 0);
        check("clr_state", 32'(state), 2);

        // Dropping arm mid-capture captures nothing that cycle.
        push(32'h4000, 32'h1);
        push(32'h4004, 32'h2);
        arm = 1'b0;
        push(32'h4008, 32'h3);
        check("disarm_state", 32'(state), 0);
        check("disarm_count", 32'(count), 2);
        deq_rdy = 1'b1;
        repeat (2) tick();
        deq_rdy = 1'b0;

        // Wrap-around stream with deq_rdy toggling.
        arm = 1'b1; tick();
        check("rearm_state", 32'(state), 1);
        collect = 1'b1;
        for (int i = 0; i < 40; i++) begin
            trace_val  = (i % 2 == 0);
            trace_addr = 32'h200 + 32'(4 * (i / 2));
            trace_data = 32'(i / 2);
            deq_rdy    = (i % 2 == 1);
            tick();
        end
        trace_val = 1'b0; deq_rdy = 1'b1;
        for (int i = 0; i < 20 && deq_val; i++) tick();
        collect = 1'b0;
        check("wrap_len", 32'(out_q.size()), 20);
        for (int k = 0; k < 20 && k < out_q.size(); k++)
            check($sformatf("wrap%0d", k), out_q[k], 32'h200 + 32'(4 * k));

        // Randomized traffic against the model.
        trig_addr = 32'h108;
        for (int i = 0; i < 400; i++) begin
            arm        = ($urandom_range(15) != 0);
            trace_val  = ($urandom_range(3) != 0);
            trace_addr = 32'h100 + 32'(4 * $urandom_range(3));
            trace_data = $urandom;
            deq_rdy    = $urandom_range(1);
            clear      = ($urandom_range(31) == 0);
            tick();
        end
        clear = 1'b0; trace_val = 1'b0; deq_rdy = 1'b0;

        // Asynchronous reset with 5 entries held.
        arm = 1'b0; tick();
        arm = 1'b1; trig_addr = 32'h300; tick();
        clear = 1'b1; tick(); clear = 1'b0;
        for (int i = 0; i < 10; i++) push(32'h300 + 32'(4 * i), 32'(i));
        deq_rdy = 1'b1; repeat (3) tick(); deq_rdy = 1'b0;
        check("prerst_count", 32'(count), 5);
        check("prerst_ovf",   32'(overflow_cnt), 2);
        #3;
        rst = 1'b0;
        #1;
        check("arst_count", 32'(count), 0);
        check("arst_val",   32'(deq_val), 0);
        check("arst_ovf",   32'(overflow_cnt), 0);
        check("arst_state", 32'(state), 0);
        check("arst_full",  32'(full), 0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;

        arm = 1'b1; tick();
        push(32'h300, 32'hA);
        push(32'h304, 32'hB);
`ifdef TRACE_CAPTURE_TSTAMP_EN
        begin
            logic [31:0] first_ts;
            first_ts = deq_tstamp;
            check("ts_first", first_ts, 32'd1);
            deq_rdy = 1'b1; tick(); deq_rdy = 1'b0;
            check("ts_second", deq_tstamp, 32'd2);
            check("ts_delta",  deq_tstamp - first_ts, 32'd1);
        end
`else
        check("ts_tied0", deq_tstamp, 32'd0);
        deq_rdy = 1'b1; tick(); deq_rdy = 1'b0;
        check("ts_tied0_b", deq_tstamp, 32'd0);
`endif
        check("post_rst_count", 32'(count), 1);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
